// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream packer.
package stream_pkg;

  localparam int DEFAULT_VALUE_WIDTH = 8;
  localparam int DEFAULT_RATIO       = 4;

  // Lane counter width; never below 1 so the counter always has a bit.
  function automatic int cnt_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_packer.sv
// Width up-converter: packs RATIO narrow words into one wide word, with
// per-lane keep flags and early close on in_last_i.
module stream_packer
  import stream_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int RATIO       = DEFAULT_RATIO
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [VALUE_WIDTH-1:0]       in_value_i,
  input  logic                         in_last_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [RATIO*VALUE_WIDTH-1:0] out_value_o,
  output logic [RATIO-1:0]             out_keep_o,
  output logic                         out_last_o
);

  localparam int CNT_W = cnt_width(RATIO);

  logic [CNT_W-1:0]             cnt;
  logic [RATIO*VALUE_WIDTH-1:0] acc;
  logic [RATIO*VALUE_WIDTH-1:0] merged;
  logic [RATIO-1:0]             keep_mask;
  logic                         accept;
  logic                         completing;
  logic                         consume;

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // in_ready_o depends only on the output slot, never on in_valid_i.
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign consume    = out_valid_o && out_ready_i;
  assign completing = accept && ((cnt == CNT_W'(RATIO - 1)) || in_last_i);

  // Accumulator with the current beat dropped into lane cnt; lanes above
  // cnt are still zero because the accumulator clears after every word.
  always_comb begin
    merged    = acc;
    keep_mask = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) == cnt) merged[i*VALUE_WIDTH +: VALUE_WIDTH] = in_value_i;
      if (CNT_W'(i) <= cnt) keep_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt         <= '0;
      acc         <= '0;
      out_valid_o <= 1'b0;
      out_value_o <= '0;
      out_keep_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (completing) begin
      out_value_o <= merged;
      out_keep_o  <= keep_mask;
      out_last_o  <= in_last_i;
      out_valid_o <= 1'b1;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      if (accept) begin
        acc <= merged;
        cnt <= cnt + CNT_W'(1);
      end
      // Output fields hold their last values while the slot is empty.
      if (consume) out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer: queue-based model checked every cycle,
// plus hand-computed literal word checks.
module tb_stream_packer;
  localparam int VW = 8;
  localparam int R  = 4;
  localparam int W  = R * VW + R + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_value = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [R*VW-1:0] out_value;
  logic [R-1:0]  out_keep;
  logic          out_last;

  int tests = 0;
  int fails = 0;

  stream_packer #(.VALUE_WIDTH(VW), .RATIO(R)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_value_i(in_value), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_value_o(out_value), .out_keep_o(out_keep), .out_last_o(out_last)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words collected per output, expected queue of
  // {last, keep, value}, and whether an output word is waiting.
  logic [VW-1:0] lanes[$];
  logic [W-1:0]  exp_q[$];
  bit            full = 0;
  bit            started = 0;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      lanes.delete();
      exp_q.delete();
      full = 0;
    end else begin
      bit take;
      take = in_valid && (!full || out_ready);
      if (full && out_ready) begin
        void'(exp_q.pop_front());
        full = 0;
      end
      if (take) begin
        lanes.push_back(in_value);
        if (lanes.size() == R || in_last) begin
          logic [R*VW-1:0] v;
          logic [R-1:0]    k;
          v = '0;
          k = '0;
          for (int i = 0; i < lanes.size(); i++) begin
            v[i*VW +: VW] = lanes[i];
            k[i] = 1'b1;
          end
          exp_q.push_back({in_last, k, v});
          full = 1;
          lanes.delete();
        end
      end
    end
  end

  // Scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(full));
      check("in_ready", 64'(in_ready), 64'(!full || out_ready));
      if (full && out_valid) begin
        if (exp_q.size() == 0) check("exp_q_empty", 64'(1), 64'(0));
        else begin
          check("sb_value", 64'(out_value), 64'(exp_q[0][R*VW-1:0]));
          check("sb_keep", 64'(out_keep), 64'(exp_q[0][R*VW +: R]));
          check("sb_last", 64'(out_last), 64'(exp_q[0][W-1]));
        end
      end
    end
  end

  // Driver tasks: called at a negedge, return at the negedge after acceptance.
  task automatic send(input logic [VW-1:0] v, input logic l);
    int n;
    in_valid = 1'b1;
    in_value = v;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'(0), 64'(1));
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expect_word(input string name, input logic [R*VW-1:0] v,
                             input logic [R-1:0] k, input logic l);
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_value"}, 64'(out_value), 64'(v));
    check({name, "_keep"}, 64'(out_keep), 64'(k));
    check({name, "_last"}, 64'(out_last), 64'(l));
  endtask

  initial begin
    // Reset held 2 cycles with valid input present
    in_valid = 1'b1;
    in_value = 8'h77;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_keep", 64'(out_keep), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_value", 64'(out_value), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;
    idle(1);

    // Full word
    for (int i = 1; i <= 4; i++) send(VW'(i), 1'b0);
    expect_word("full", 32'h04030201, 4'b1111, 1'b0);
    idle(1);
    check("full_one_cycle", 64'(out_valid), 64'(0));

    // Early flush, then a full word
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    expect_word("flush", 32'h00000B0A, 4'b0011, 1'b1);
    for (int i = 0; i < 4; i++) send(VW'(8'h11 + i), 1'b0);
    expect_word("after_flush", 32'h14131211, 4'b1111, 1'b0);

    // Last on the first beat and on the final lane
    send(8'h55, 1'b1);
    expect_word("single", 32'h00000055, 4'b0001, 1'b1);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b1);
    expect_word("full_last", 32'h64636261, 4'b1111, 1'b1);
    idle(2);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(VW'(i), 1'b0);
    in_valid = 1'b1;
    in_value = 8'h21;
    for (int c = 0; c < 5; c++) begin
      check("bp_ready", 64'(in_ready), 64'(0));
      expect_word("bp_hold", 32'h04030201, 4'b1111, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 4; i++) send(VW'(8'h21 + i), 1'b0);
    expect_word("bp_next", 32'h24232221, 4'b1111, 1'b0);
    idle(2);

    // Streaming 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      check("stream_no_stall", 64'(in_ready), 64'(1));
      send(VW'(i), 1'b0);
      if (i % 4 == 3)
        expect_word("stream", {VW'(i), VW'(i - 1), VW'(i - 2), VW'(i - 3)}, 4'b1111, 1'b0);
      else
        check("stream_gap", 64'(out_valid), 64'(0));
    end
    idle(2);

    // Reset mid-word
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) send(VW'(i), 1'b0);
    expect_word("post_reset", 32'h04030201, 4'b1111, 1'b0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
